// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side (wclk domain).
// Grants bursts of up to MAX_BURST beats and never writes while the FIFO is full.
module async_fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    output logic                      winc,
    output logic [DSIZE-1:0]          wdata,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [15:0]               xfer_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_owner;
    logic [BCW-1:0]   r_beat_cnt;
    logic [15:0]      r_xfer_count;

    logic             w_grant_found;
    logic [IDW-1:0]   w_grant_idx;
    logic [IDW-1:0]   w_cand;
    logic             w_owner_valid;
    logic             w_last_beat;

    // Round-robin search starting just after the previous owner.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_owner_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDW'(i)) begin
                w_owner_valid = req_valid[i];
            end
        end
    end

    assign w_last_beat = (r_beat_cnt == BCW'(MAX_BURST - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en && w_grant_found) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if ((winc && w_last_beat) || !w_owner_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Write strobe, ready and data mux are purely combinational off the owner.
    always_comb begin
        winc      = 1'b0;
        req_ready = '0;
        wdata     = '0;
        busy      = (r_state == ST_BURST);
        if (r_state == ST_BURST) begin
            winc = w_owner_valid & ~wfull;
            for (int i = 0; i < NREQ; i++) begin
                if (r_owner == IDW'(i)) begin
                    req_ready[i] = ~wfull;
                    wdata        = req_data[i*DSIZE +: DSIZE];
                end
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_rr_ptr     <= IDW'(NREQ - 1);
            r_owner      <= '0;
            r_beat_cnt   <= '0;
            r_xfer_count <= '0;
        end else begin
            if (r_state == ST_IDLE && w_next_state == ST_BURST) begin
                r_owner    <= w_grant_idx;
                r_beat_cnt <= '0;
            end
            if (winc) begin
                r_beat_cnt   <= r_beat_cnt + BCW'(1);
                r_xfer_count <= r_xfer_count + 16'd1;
            end
            if (r_state == ST_BURST && w_next_state == ST_IDLE) begin
                r_rr_ptr <= r_owner;
            end
        end
    end

    assign grant_id   = r_owner;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: producers modelled as counters,
// expected beats queued by the stimulus and checked by an independent monitor.
module tb_async_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
    } beat_t;

    logic                  wclk;
    logic                  wrst_n;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;
    logic [1:0]            grant_id;
    logic [15:0]           xfer_count;

    int         n_checks;
    int         n_fail;
    beat_t      sb[$];
    int         left[NREQ];
    logic [7:0] nxt[NREQ];

    async_fifo_wr_arbiter #(
        .DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy),
        .grant_id(grant_id), .xfer_count(xfer_count)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    assert property (@(posedge wclk) disable iff (!wrst_n) !(winc && wfull));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = (left[i] > 0);
            req_data[i*DSIZE +: DSIZE] = nxt[i];
        end
    endtask

    // One clock: record handshakes before the edge, advance producers after it.
    task automatic tick();
        logic [NREQ-1:0] fire;
        @(negedge wclk);
        fire = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i]) begin
                left[i]--;
                nxt[i]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic expect_beats(input int id, input logic [7:0] first, input int n);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.id = 2'(id);
            b.d  = first + 8'(j);
            sb.push_back(b);
        end
    endtask

    task automatic load(input int id, input int n, input logic [7:0] first);
        left[id] = n;
        nxt[id]  = first;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            nxt[i]  = 8'h00;
        end
        drive();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        clear_sources();
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #2;
    endtask

    // Monitor: every written beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge wclk);
            if (wrst_n) begin
                check("no_winc_when_full", 32'(winc & wfull), 32'd0);
                if (winc) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got owner %0d data %0h expected no beat", grant_id, wdata);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", 32'(wdata), 32'(e.d));
                        check("beat_owner", 32'(grant_id), 32'(e.id));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pat1;
        logic [8:0]  pat5;
        int          guard;

        n_checks = 0;
        n_fail   = 0;
        wrst_n   = 1'b0;
        en       = 1'b0;
        wfull    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        clear_sources();

        // Reset values
        #12;
        check("rst_winc", 32'(winc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #2;

        // Test 1: single requester, two bursts of 4 with one idle cycle between
        en = 1'b1;
        load(0, 8, 8'h10);
        drive();
        expect_beats(0, 8'h10, 8);
        pat1 = 11'b0_1111_0_1111_0;
        for (int k = 0; k <= 10; k++) begin
            check("t1_busy", 32'(busy), 32'(pat1[k]));
            tick();
        end
        check("t1_xfer_count", 32'(xfer_count), 32'd8);
        check("t1_grant_id", 32'(grant_id), 32'd0);

        // Test 2: all four requesters valid, round-robin 0,1,2,3,0
        do_reset();
        check("t2_xfer_after_reset", 32'(xfer_count), 32'd0);
        load(0, 8, 8'h20);
        load(1, 4, 8'h30);
        load(2, 4, 8'h40);
        load(3, 4, 8'h50);
        drive();
        expect_beats(0, 8'h20, 4);
        expect_beats(1, 8'h30, 4);
        expect_beats(2, 8'h40, 4);
        expect_beats(3, 8'h50, 4);
        expect_beats(0, 8'h24, 4);
        for (int k = 0; k <= 25; k++) begin
            check("t2_busy", 32'(busy), (k % 5 != 0) ? 32'd1 : 32'd0);
            tick();
        end
        check("t2_xfer_count", 32'(xfer_count), 32'd20);

        // Test 3: requester 2, FIFO full for 5 cycles after beat 2
        load(2, 4, 8'h60);
        drive();
        expect_beats(2, 8'h60, 4);
        tick();
        tick();
        tick();
        for (int j = 0; j < 5; j++) begin
            wfull = 1'b1;
            #1;
            check("t3_full_winc", 32'(winc), 32'd0);
            check("t3_full_ready", 32'(req_ready), 32'd0);
            check("t3_full_grant", 32'(grant_id), 32'd2);
            check("t3_full_busy", 32'(busy), 32'd1);
            tick();
        end
        wfull = 1'b0;
        #1;
        check("t3_resume_winc", 32'(winc), 32'd1);
        tick();
        tick();
        tick();
        check("t3_busy_end", 32'(busy), 32'd0);
        check("t3_xfer_count", 32'(xfer_count), 32'd24);

        // Test 4: requester 1 drops valid after 2 beats; next grant goes to 2
        load(1, 2, 8'h70);
        drive();
        expect_beats(1, 8'h70, 2);
        expect_beats(2, 8'h90, 1);
        expect_beats(3, 8'hA0, 1);
        expect_beats(0, 8'h80, 1);
        tick();
        check("t4_grant1", 32'(grant_id), 32'd1);
        tick();
        tick();
        load(0, 1, 8'h80);
        load(2, 1, 8'h90);
        load(3, 1, 8'hA0);
        drive();
        #1;
        check("t4_drop_busy", 32'(busy), 32'd1);
        check("t4_drop_winc", 32'(winc), 32'd0);
        tick();
        check("t4_idle_after_drop", 32'(busy), 32'd0);
        tick();
        check("t4_next_grant", 32'(grant_id), 32'd2);
        for (int k = 0; k < 10; k++) tick();
        check("t4_xfer_count", 32'(xfer_count), 32'd29);

        // Test 5: en low blocks grants; en dropped mid-burst lets it finish
        en = 1'b0;
        load(0, 4, 8'hB0);
        load(1, 4, 8'hC0);
        load(2, 4, 8'hD0);
        load(3, 4, 8'hE0);
        drive();
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t5_dis_winc", 32'(winc), 32'd0);
            check("t5_dis_busy", 32'(busy), 32'd0);
            tick();
        end
        en = 1'b1;
        expect_beats(1, 8'hC0, 4);
        pat5 = 9'b0000_1111_0;
        for (int k = 0; k <= 8; k++) begin
            check("t5_busy", 32'(busy), 32'(pat5[k]));
            if (k == 1) en = 1'b0;
            tick();
        end
        check("t5_xfer_count", 32'(xfer_count), 32'd33);
        check("t5_grant_hold", 32'(grant_id), 32'd1);

        // Test 6: reset during beat 3 of requester 2's burst
        en = 1'b1;
        expect_beats(2, 8'hD0, 2);
        tick();
        tick();
        tick();
        check("t6_beat3_winc", 32'(winc), 32'd1);
        wrst_n = 1'b0;
        #1;
        check("t6_rst_winc", 32'(winc), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_xfer", 32'(xfer_count), 32'd0);
        check("t6_rst_grant", 32'(grant_id), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
        expect_beats(0, 8'hB0, 4);
        expect_beats(2, 8'hD2, 2);
        expect_beats(3, 8'hE0, 4);
        @(posedge wclk);
        #2;
        check("t6_first_grant", 32'(grant_id), 32'd0);
        check("t6_first_busy", 32'(busy), 32'd1);
        guard = 0;
        while ((left[0] + left[1] + left[2] + left[3]) > 0 && guard < 60) begin
            tick();
            guard++;
        end
        check("t6_drain_in_time", 32'(guard < 60), 32'd1);
        tick();
        tick();
        check("t6_xfer_count", 32'(xfer_count), 32'd10);
        check("t6_busy_end", 32'(busy), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
